data_mem_access: RTL and testbench

//  MEM-stage access controller between the pipeline and a variable-latency word-wide Data Memory.

---
 rtl/data_mem_access_pkg.sv | 47 ++++
 rtl/data_mem_access_if.sv | 49 ++++
 rtl/data_mem_access_store_align.sv | 49 ++++
 rtl/data_mem_access.sv | 164 ++++++++++++++++
 tb/tb_data_mem_access.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_access_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : data_mem_access_pkg                                            |
// | Purpose : Shared codes for the MEM-stage data memory access controller:  |
// |           store-type codes, RegWrite/load-type codes, FSM state codes    |
// |           and the alignment rule.                                        |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package data_mem_access_pkg;

    // Store type codes (ReqStoreType)
    localparam logic [1:0] STORE_NONE = 2'd0;
    localparam logic [1:0] SB         = 2'd1;
    localparam logic [1:0] SH         = 2'd2;
    localparam logic [1:0] SW         = 2'd3;

    // RegWrite / load type codes (ReqLoadType, LoadRegWrite)
    localparam logic [2:0] NOREGWRITE = 3'd0;
    localparam logic [2:0] LB         = 3'd1;
    localparam logic [2:0] LH         = 3'd2;
    localparam logic [2:0] LW         = 3'd3;
    localparam logic [2:0] LBU        = 3'd4;
    localparam logic [2:0] LHU        = 3'd5;

    // Controller FSM state codes
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // An access is misaligned when it would cross the 32-bit word boundary.
    // A nonzero store type takes precedence; the load type is then ignored.
    function automatic logic is_misaligned(input logic [1:0] store_type,
                                           input logic [2:0] load_type,
                                           input logic [1:0] b);
        logic half;
        logic word;
        half = (store_type == SH) ||
               ((store_type == STORE_NONE) && ((load_type == LH) || (load_type == LHU)));
        word = (store_type == SW) ||
               ((store_type == STORE_NONE) && (load_type == LW));
        return (half && (b == 2'd3)) || (word && (b != 2'd0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_access_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : data_mem_access_if                                             |
// | Purpose : Pipeline request/response and data-memory bus bundle.          |
// |           master : the access controller (accepts requests, drives Mem*) |
// |           slave  : the environment (pipeline + data memory)              |
// | Ports   : Req* pipeline request, Mem* memory handshake, Load* response   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface data_mem_access_if;
    logic        ReqValid;
    logic        ReqReady;
    logic [31:0] ReqAddr;
    logic [31:0] ReqStoreData;
    logic [1:0]  ReqStoreType;
    logic [2:0]  ReqLoadType;
    logic        ReqDone;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic [3:0]  MemWE;
    logic [31:0] MemWData;
    logic        MemAck;
    logic [31:0] MemRData;
    logic [31:0] LoadWord;
    logic [1:0]  LoadedBytesSelect;
    logic [2:0]  LoadRegWrite;
    logic        LoadValid;
    logic        MisalignErr;
    logic        TimeoutErr;

    modport master (
        input  ReqValid, ReqAddr, ReqStoreData, ReqStoreType, ReqLoadType,
        input  MemAck, MemRData,
        output ReqReady, ReqDone,
        output MemReq, MemAddr, MemWE, MemWData,
        output LoadWord, LoadedBytesSelect, LoadRegWrite, LoadValid,
        output MisalignErr, TimeoutErr
    );

    modport slave (
        output ReqValid, ReqAddr, ReqStoreData, ReqStoreType, ReqLoadType,
        output MemAck, MemRData,
        input  ReqReady, ReqDone,
        input  MemReq, MemAddr, MemWE, MemWData,
        input  LoadWord, LoadedBytesSelect, LoadRegWrite, LoadValid,
        input  MisalignErr, TimeoutErr
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_access_store_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : data_mem_access_store_align                                    |
// | Purpose : Combinational store lane steering. Replicates right-aligned    |
// |           store data across the word and builds byte write-enables.      |
// | Ports   : i_store_type  store code (none/SB/SH/SW)                       |
// |           i_byte_sel    ReqAddr[1:0]                                     |
// |           i_data        right-aligned store source                       |
// |           o_we          byte write-enables (0 when no store)             |
// |           o_wdata       replicated write data                            |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module data_mem_access_store_align
    import data_mem_access_pkg::*;
(
    input  logic [1:0]  i_store_type,
    input  logic [1:0]  i_byte_sel,
    input  logic [31:0] i_data,
    output logic [3:0]  o_we,
    output logic [31:0] o_wdata
);

    // Data is replicated so the memory picks the right lanes purely from the
    // write-enables; no barrel shift of the data is needed.
    always_comb begin
        o_we    = 4'b0000;
        o_wdata = 32'h0;
        case (i_store_type)
            SB: begin
                o_we    = 4'b0001 << i_byte_sel;
                o_wdata = {4{i_data[7:0]}};
            end
            SH: begin
                o_we    = 4'b0011 << i_byte_sel;
                o_wdata = {2{i_data[15:0]}};
            end
            SW: begin
                o_we    = 4'b1111;
                o_wdata = i_data;
            end
            default: begin
                o_we    = 4'b0000;
                o_wdata = 32'h0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_access.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : data_mem_access                                                |
// | Purpose : MEM-stage access controller. Accepts one load/store, issues it |
// |           to a variable-latency word-wide data memory with a req/ack     |
// |           handshake and timeout, returns the raw load word to the        |
// |           load-extension stage and flags misaligned accesses.            |
// | Ports   : CPU_CLK    clock, rising edge                                  |
// |           CPU_RST_N  asynchronous active-low reset                       |
// |           bus        data_mem_access_if.master (Req*, Mem*, Load*, errs) |
// | Params  : MEM_TIMEOUT  max WAIT cycles before TimeoutErr (0 = disabled)  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module data_mem_access
    import data_mem_access_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
)(
    input  wire logic          CPU_CLK,
    input  wire logic          CPU_RST_N,
    data_mem_access_if.master  bus
);

    // Width floors at 1 so the disabled-timeout build still has a legal vector.
    localparam int c_cnt_w = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;

    state_e              state_q,     state_d;
    logic [c_cnt_w-1:0]  cnt_q,       cnt_d;
    logic                mem_req_q,   mem_req_d;
    logic [31:0]         mem_addr_q,  mem_addr_d;
    logic [3:0]          mem_we_q,    mem_we_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         load_word_q, load_word_d;
    logic [1:0]          sel_q,       sel_d;
    logic [2:0]          rtype_q,     rtype_d;
    logic                mis_q,       mis_d;
    logic                tmo_q,       tmo_d;

    logic [3:0]          w_we;
    logic [31:0]         w_wdata;
    logic                w_accept;
    logic                w_misaligned;
    logic                w_noop;

    data_mem_access_store_align u_store_align (
        .i_store_type (bus.ReqStoreType),
        .i_byte_sel   (bus.ReqAddr[1:0]),
        .i_data       (bus.ReqStoreData),
        .o_we         (w_we),
        .o_wdata      (w_wdata)
    );

    assign w_accept     = bus.ReqValid && (state_q == S_IDLE);
    assign w_misaligned = is_misaligned(bus.ReqStoreType, bus.ReqLoadType, bus.ReqAddr[1:0]);
    assign w_noop       = (bus.ReqStoreType == STORE_NONE) && (bus.ReqLoadType == NOREGWRITE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        load_word_d = load_word_q;
        sel_d       = sel_q;
        rtype_d     = rtype_q;
        mis_d       = mis_q;
        tmo_d       = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    sel_d   = bus.ReqAddr[1:0];
                    mis_d   = 1'b0;
                    tmo_d   = 1'b0;
                    cnt_d   = '0;
                    rtype_d = NOREGWRITE;
                    if (w_misaligned) begin
                        mis_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (w_noop) begin
                        state_d = S_DONE;
                    end else begin
                        mem_addr_d  = {bus.ReqAddr[31:2], 2'b00};
                        mem_we_d    = w_we;
                        mem_wdata_d = w_wdata;
                        // A store takes priority; a simultaneous load never writes back.
                        rtype_d     = (bus.ReqStoreType != STORE_NONE) ? NOREGWRITE
                                                                       : bus.ReqLoadType;
                        mem_req_d   = 1'b1;
                        state_d     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Ack is checked first so an ack on the last allowed cycle wins.
                if (bus.MemAck) begin
                    load_word_d = bus.MemRData;
                    mem_req_d   = 1'b0;
                    state_d     = S_DONE;
                end else if ((MEM_TIMEOUT > 0) && (cnt_q == c_tmo_last)) begin
                    mem_req_d   = 1'b0;
                    tmo_d       = 1'b1;
                    rtype_d     = NOREGWRITE;
                    state_d     = S_DONE;
                end else if (cnt_q != c_cnt_max) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_we_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            load_word_q <= 32'h0;
            sel_q       <= 2'd0;
            rtype_q     <= NOREGWRITE;
            mis_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            load_word_q <= load_word_d;
            sel_q       <= sel_d;
            rtype_q     <= rtype_d;
            mis_q       <= mis_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.ReqReady          = (state_q == S_IDLE);
    assign bus.ReqDone           = (state_q == S_DONE);
    assign bus.MemReq            = mem_req_q;
    assign bus.MemAddr           = mem_addr_q;
    assign bus.MemWE             = mem_we_q;
    assign bus.MemWData          = mem_wdata_q;
    assign bus.LoadWord          = load_word_q;
    assign bus.LoadedBytesSelect = sel_q;
    assign bus.LoadRegWrite      = rtype_q;
    // Error/store/no-op paths leave rtype at NOREGWRITE, so this is load success.
    assign bus.LoadValid         = (state_q == S_DONE) && !mis_q && !tmo_q && (rtype_q != NOREGWRITE);
    assign bus.MisalignErr       = (state_q == S_DONE) && mis_q;
    assign bus.TimeoutErr        = (state_q == S_DONE) && tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_access.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_data_mem_access                                             |
// | Purpose : Self-checking bench for data_mem_access with a behavioural     |
// |           model of alignment, lane replication, latency and capture.     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_data_mem_access;
    import data_mem_access_pkg::*;

    localparam int TMO = 8;

    // One observed/expected record per request.
    typedef struct packed {
        logic        req_seen;
        logic        bus_ok;
        logic [31:0] mem_addr;
        logic [3:0]  mem_we;
        logic [31:0] mem_wdata;
        logic [7:0]  latency;
        logic        load_valid;
        logic        mis;
        logic        tmo;
        logic [31:0] load_word;
        logic [1:0]  sel;
        logic [2:0]  rtype;
        logic        after_ok;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] model_word = 32'h0;
    logic [2:0]  lt_tab [6] = '{NOREGWRITE, LB, LH, LW, LBU, LHU};

    data_mem_access_if bus_if ();

    data_mem_access #(.MEM_TIMEOUT(TMO)) dut (
        .CPU_CLK   (clk),
        .CPU_RST_N (rst_n),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: access size from the code, word-crossing = misaligned,
    // byte lane i carries source byte (i mod size), latency from ack position.
    function automatic res_t model(input logic [31:0] addr, input logic [31:0] data,
                                   input logic [1:0] st, input logic [2:0] lt,
                                   input int ack_delay, input logic [31:0] rdata);
        res_t e;
        int   size;
        int   b;
        bit   acked;
        e = '0;
        e.bus_ok   = 1'b1;
        e.after_ok = 1'b1;
        e.sel      = addr[1:0];
        e.rtype    = NOREGWRITE;
        b = int'(addr[1:0]);
        if (st != 0) size = (st == 1) ? 1 : (st == 2) ? 2 : 4;
        else if (lt == LB || lt == LBU) size = 1;
        else if (lt == LH || lt == LHU) size = 2;
        else if (lt == LW) size = 4;
        else size = 0;
        if (size == 0) begin
            e.latency = 8'd1;
        end else if (b + size > 4) begin
            e.latency = 8'd1;
            e.mis     = 1'b1;
        end else begin
            e.req_seen = 1'b1;
            e.mem_addr = addr & 32'hFFFF_FFFC;
            if (st != 0) begin
                e.mem_we = 4'(((1 << size) - 1) << b);
                for (int i = 0; i < 4; i++) e.mem_wdata[8*i +: 8] = data[8*(i % size) +: 8];
            end
            acked     = (ack_delay >= 0) && (ack_delay < TMO);
            e.latency = acked ? 8'(ack_delay + 2) : 8'(TMO + 1);
            e.tmo     = !acked;
            if (acked) model_word = rdata;
            e.load_valid = acked && (st == 0);
            e.rtype      = e.load_valid ? lt : NOREGWRITE;
        end
        e.load_word = model_word;
        return e;
    endfunction

    // Drives one request (called at a negedge in IDLE), acks after ack_delay
    // WAIT cycles (negative = never) and records what the DUT did.
    task automatic run_req(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] st, input logic [2:0] lt,
                           input int ack_delay, input logic [31:0] rdata, output res_t r);
        r = '0;
        r.bus_ok   = 1'b1;
        r.after_ok = 1'b1;
        r.latency  = 8'hFF;
        if (bus_if.ReqReady !== 1'b1) r.bus_ok = 1'b0;
        bus_if.ReqValid     = 1'b1;
        bus_if.ReqAddr      = addr;
        bus_if.ReqStoreData = data;
        bus_if.ReqStoreType = st;
        bus_if.ReqLoadType  = lt;
        bus_if.MemAck       = 1'($urandom_range(0, 1));   // ignored outside WAIT
        bus_if.MemRData     = $urandom;
        @(posedge clk);
        #1;
        bus_if.ReqValid     = 1'b0;
        bus_if.ReqAddr      = $urandom;
        bus_if.ReqStoreData = $urandom;
        bus_if.ReqStoreType = 2'($urandom);
        bus_if.ReqLoadType  = 3'($urandom);
        bus_if.MemAck       = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus_if.MemAck = 1'b0;
            if (bus_if.ReqDone === 1'b1) begin
                r.latency = 8'(c);
                break;
            end
            if (c == 1) begin
                r.req_seen  = bus_if.MemReq;
                r.mem_addr  = bus_if.MemAddr;
                r.mem_we    = bus_if.MemWE;
                r.mem_wdata = (bus_if.MemWE == 4'h0) ? 32'h0 : bus_if.MemWData;
            end else if (bus_if.MemAddr !== r.mem_addr || bus_if.MemWE !== r.mem_we) begin
                r.bus_ok = 1'b0;
            end
            if (bus_if.MemReq !== 1'b1 || bus_if.ReqReady !== 1'b0) r.bus_ok = 1'b0;
            if (c - 1 == ack_delay) begin
                bus_if.MemAck   = 1'b1;
                bus_if.MemRData = rdata;
            end else begin
                bus_if.MemRData = $urandom;
            end
        end
        r.load_valid = bus_if.LoadValid;
        r.mis        = bus_if.MisalignErr;
        r.tmo        = bus_if.TimeoutErr;
        r.load_word  = bus_if.LoadWord;
        r.sel        = bus_if.LoadedBytesSelect;
        r.rtype      = bus_if.LoadRegWrite;
        if (bus_if.MemReq !== 1'b0 || bus_if.ReqReady !== 1'b0) r.bus_ok = 1'b0;
        bus_if.MemAck   = 1'($urandom_range(0, 1));       // ignored in DONE
        bus_if.MemRData = $urandom;
        @(negedge clk);
        bus_if.MemAck = 1'b0;
        if (bus_if.ReqDone !== 1'b0 || bus_if.ReqReady !== 1'b1 || bus_if.LoadValid !== 1'b0 ||
            bus_if.MisalignErr !== 1'b0 || bus_if.TimeoutErr !== 1'b0 || bus_if.MemReq !== 1'b0 ||
            bus_if.LoadWord !== r.load_word)
            r.after_ok = 1'b0;
    endtask

    task automatic test_reset();
        logic [111:0] got;
        logic [111:0] exp;
        got = {bus_if.ReqReady, bus_if.ReqDone, bus_if.MemReq, bus_if.MemAddr, bus_if.MemWE,
               bus_if.MemWData, bus_if.LoadWord, bus_if.LoadedBytesSelect, bus_if.LoadRegWrite,
               bus_if.LoadValid, bus_if.MisalignErr, bus_if.TimeoutErr};
        exp = {1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 2'd0, NOREGWRITE, 3'b000};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", got, exp);
        end
    endtask

    task automatic test_sw();
        res_t r, e;
        e = model(32'h100, 32'hDEADBEEF, SW, NOREGWRITE, 0, 32'h1234_5678);
        run_req(32'h100, 32'hDEADBEEF, SW, NOREGWRITE, 0, 32'h1234_5678, r);
        checks++; if (r.mem_addr !== 32'h100) begin errors++; $display("FAIL sw_addr got %h exp %h", r.mem_addr, 32'h100); end
        checks++; if (r.mem_we !== 4'hF) begin errors++; $display("FAIL sw_we got %h exp %h", r.mem_we, 4'hF); end
        checks++; if (r.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h exp %h", r.mem_wdata, 32'hDEADBEEF); end
        // accept cycle, one WAIT, DONE: pulse on the 2nd negedge after the accept edge
        checks++; if (r.latency !== 8'd2) begin errors++; $display("FAIL sw_latency got %0d exp 2", r.latency); end
        checks++; if (r !== e) begin errors++; $display("FAIL sw_record got %h exp %h", r, e); end
    endtask

    task automatic test_sb();
        res_t r, e;
        e = model(32'h203, 32'h0000_00A5, SB, NOREGWRITE, 1, 32'h0);
        run_req(32'h203, 32'h0000_00A5, SB, NOREGWRITE, 1, 32'h0, r);
        checks++; if (r.mem_addr !== 32'h200) begin errors++; $display("FAIL sb_addr got %h exp %h", r.mem_addr, 32'h200); end
        checks++; if (r.mem_we !== 4'h8) begin errors++; $display("FAIL sb_we got %h exp %h", r.mem_we, 4'h8); end
        checks++; if (r.mem_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %h exp %h", r.mem_wdata, 32'hA5A5A5A5); end
        checks++; if (r.load_valid !== 1'b0) begin errors++; $display("FAIL sb_loadvalid got %b exp 0", r.load_valid); end
        checks++; if (r !== e) begin errors++; $display("FAIL sb_record got %h exp %h", r, e); end
    endtask

    task automatic test_lh();
        res_t r, e;
        e = model(32'h106, 32'h0, 2'd0, LH, 4, 32'h80017FFF);
        run_req(32'h106, 32'h0, 2'd0, LH, 4, 32'h80017FFF, r);
        checks++; if (r.load_word !== 32'h80017FFF) begin errors++; $display("FAIL lh_word got %h exp %h", r.load_word, 32'h80017FFF); end
        checks++; if (r.sel !== 2'd2) begin errors++; $display("FAIL lh_sel got %0d exp 2", r.sel); end
        checks++; if (r.rtype !== LH) begin errors++; $display("FAIL lh_rtype got %0d exp %0d", r.rtype, LH); end
        checks++; if (r.load_valid !== 1'b1 || r.mem_we !== 4'h0) begin errors++; $display("FAIL lh_valid_we got %b/%h exp 1/0", r.load_valid, r.mem_we); end
        checks++; if (r !== e) begin errors++; $display("FAIL lh_record got %h exp %h", r, e); end
    endtask

    task automatic test_misalign();
        res_t r, e;
        e = model(32'h102, 32'h0, 2'd0, LW, 0, 32'hFFFF_FFFF);
        run_req(32'h102, 32'h0, 2'd0, LW, 0, 32'hFFFF_FFFF, r);
        checks++; if (r.mis !== 1'b1 || r.req_seen !== 1'b0 || r.latency !== 8'd1) begin errors++; $display("FAIL lw_misalign got mis %b req %b lat %0d exp 1 0 1", r.mis, r.req_seen, r.latency); end
        checks++; if (r !== e) begin errors++; $display("FAIL lw_mis_record got %h exp %h", r, e); end
        e = model(32'h107, 32'h0, 2'd0, LHU, 0, 32'hFFFF_FFFF);
        run_req(32'h107, 32'h0, 2'd0, LHU, 0, 32'hFFFF_FFFF, r);
        checks++; if (r.mis !== 1'b1 || r.req_seen !== 1'b0 || r.rtype !== NOREGWRITE) begin errors++; $display("FAIL lhu_misalign got mis %b req %b rw %0d exp 1 0 0", r.mis, r.req_seen, r.rtype); end
        checks++; if (r !== e) begin errors++; $display("FAIL lhu_mis_record got %h exp %h", r, e); end
    endtask

    task automatic test_timeout();
        res_t r, e;
        e = model(32'h40, 32'h0, 2'd0, LW, -1, 32'h0);
        run_req(32'h40, 32'h0, 2'd0, LW, -1, 32'h0, r);
        checks++; if (r.tmo !== 1'b1 || r.latency !== 8'(TMO + 1) || r.load_valid !== 1'b0) begin errors++; $display("FAIL timeout got tmo %b lat %0d lv %b exp 1 %0d 0", r.tmo, r.latency, r.load_valid, TMO + 1); end
        checks++; if (r !== e) begin errors++; $display("FAIL timeout_record got %h exp %h", r, e); end
        // ack on the last allowed WAIT cycle beats the timeout
        e = model(32'h44, 32'h0, 2'd0, LW, TMO - 1, 32'hCAFE_F00D);
        run_req(32'h44, 32'h0, 2'd0, LW, TMO - 1, 32'hCAFE_F00D, r);
        checks++; if (r.tmo !== 1'b0 || r.load_valid !== 1'b1 || r.load_word !== 32'hCAFE_F00D) begin errors++; $display("FAIL ack_wins got tmo %b lv %b word %h exp 0 1 cafef00d", r.tmo, r.load_valid, r.load_word); end
        checks++; if (r !== e) begin errors++; $display("FAIL ack_wins_record got %h exp %h", r, e); end
    endtask

    task automatic test_reset_mid_wait();
        bus_if.ReqValid     = 1'b1;
        bus_if.ReqAddr      = 32'h300;
        bus_if.ReqStoreType = 2'd0;
        bus_if.ReqLoadType  = LW;
        bus_if.MemAck       = 1'b0;
        @(posedge clk);
        #1 bus_if.ReqValid = 1'b0;
        @(negedge clk);
        checks++; if (bus_if.MemReq !== 1'b1) begin errors++; $display("FAIL wait_memreq got %b exp 1", bus_if.MemReq); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus_if.MemReq !== 1'b0 || bus_if.ReqReady !== 1'b1) begin errors++; $display("FAIL async_reset got req %b rdy %b exp 0 1", bus_if.MemReq, bus_if.ReqReady); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_word = 32'h0;
        @(negedge clk);
        checks++; if (bus_if.ReqReady !== 1'b1 || bus_if.LoadWord !== 32'h0 || bus_if.MemReq !== 1'b0) begin errors++; $display("FAIL post_reset got rdy %b word %h req %b exp 1 0 0", bus_if.ReqReady, bus_if.LoadWord, bus_if.MemReq); end
    endtask

    task automatic test_back_to_back();
        res_t r, e;
        logic [31:0] a, d, rd;
        int dl;
        for (int i = 0; i < 16; i++) begin
            a  = $urandom;
            rd = $urandom;
            dl = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'd0;
            e = model(a, 32'h0, 2'd0, lt_tab[$urandom_range(1, 5)], dl, rd);
            run_req(a, 32'h0, 2'd0, e.load_valid ? e.rtype : lt_tab[1 + (i % 5)], dl, rd, r);
            checks++; if (r !== e && r.after_ok !== 1'b1) begin errors++; $display("FAIL b2b_pulse[%0d] got %h exp %h", i, r, e); end
        end
    endtask

    task automatic test_random_mixed();
        res_t r, e;
        logic [31:0] a, d, rd;
        logic [1:0]  st;
        logic [2:0]  lt;
        int dl;
        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            d  = $urandom;
            rd = $urandom;
            st = 2'($urandom_range(0, 3));
            lt = lt_tab[$urandom_range(0, 5)];
            dl = $urandom_range(0, TMO + 1);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'd0;
            e = model(a, d, st, lt, dl, rd);
            run_req(a, d, st, lt, dl, rd, r);
            checks++; if (r !== e) begin errors++; $display("FAIL random[%0d] st %0d lt %0d got %h exp %h", i, st, lt, r, e); end
        end
    endtask

    initial begin
        bus_if.ReqValid     = 1'b0;
        bus_if.ReqAddr      = 32'h0;
        bus_if.ReqStoreData = 32'h0;
        bus_if.ReqStoreType = 2'd0;
        bus_if.ReqLoadType  = NOREGWRITE;
        bus_if.MemAck       = 1'b0;
        bus_if.MemRData     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_sw();
        test_sb();
        test_lh();
        test_misalign();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_random_mixed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
